// File: rtl/reg_share_arbiter_if.sv
// Requester/arbiter bundle for the shared register arbiter.
// Master drives requests and data; slave returns grant, owner and contents.
interface reg_share_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 32
);
  logic [N-1:0]         req;
  logic [N-1:0]         lock;
  logic [N*WIDTH-1:0]   wdata;
  logic [N-1:0]         grant;
  logic [$clog2(N)-1:0] owner;
  logic                 busy;
  logic [WIDTH-1:0]     y;

  modport master (
    output req, lock, wdata,
    input  grant, owner, busy, y
  );

  modport slave (
    input  req, lock, wdata,
    output grant, owner, busy, y
  );
endinterface

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one clear-on-reset register among N writers,
// with a bounded lock letting an owner perform back-to-back writes.
module reg_share_arbiter #(
  parameter int N        = 4,
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 4
) (
  input logic             clk,
  input logic             reset,
  reg_share_arbiter_if.slave bus
);

  localparam int OW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, OWN} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [WIDTH-1:0] y_q, y_d;

  logic [OW-1:0]    start;
  logic [OW-1:0]    nxt;
  logic [OW-1:0]    win;
  logic             found;
  logic             o_req;
  logic             stay;

  assign nxt   = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);
  assign start = (state_q == IDLE) ? ptr_q : nxt;
  assign o_req = bus.req[owner_q];
  assign stay  = o_req && bus.lock[owner_q]
              && (hold_q < HW'(MAX_HOLD - 1));

  // Scan downward so the closest requester to start is the last to win.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % N;
      if (bus.req[idx]) begin
        found = 1'b1;
        win   = OW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWN;
          grant_d = {{(N-1){1'b0}}, 1'b1} << win;
          owner_d = win;
          hold_d  = '0;
        end
      end
      OWN: begin
        if (o_req)
          y_d = bus.wdata[int'(owner_q)*WIDTH +: WIDTH];
        if (stay) begin
          hold_d = hold_q + HW'(1);
        end else begin
          ptr_d  = nxt;
          hold_d = '0;
          if (found) begin
            grant_d = {{(N-1){1'b0}}, 1'b1} << win;
            owner_d = win;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            owner_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      y_q     <= y_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q == OWN);
  assign bus.y     = y_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench for reg_share_arbiter: the driver queues hand-computed
// expectations, the monitor compares them on each falling edge.
module tb_reg_share_arbiter;

  logic clk;
  logic reset;

  reg_share_arbiter_if #(.N(4), .WIDTH(32)) bus();

  reg_share_arbiter #(
    .N(4), .WIDTH(32), .MAX_HOLD(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0]  g;
    logic [1:0]  o;
    logic        b;
    logic [31:0] y;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pk(
    input logic [31:0] w3, input logic [31:0] w2,
    input logic [31:0] w1, input logic [31:0] w0
  );
    return {w3, w2, w1, w0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  // Monitor: one expectation per falling edge once the queue is primed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("grant", 32'(bus.grant), 32'(e.g));
        chk("owner", 32'(bus.owner), 32'(e.o));
        chk("busy",  32'(bus.busy),  32'(e.b));
        chk("y",     bus.y,          e.y);
      end
    end
  end

  task automatic cyc(
    input logic rv, input logic [3:0] r, input logic [3:0] l,
    input logic [127:0] wd,
    input logic [3:0] eg, input logic [1:0] eo, input logic eb,
    input logic [31:0] ey
  );
    exp_t e;
    @(negedge clk);
    #1;
    reset     = rv;
    bus.req   = r;
    bus.lock  = l;
    bus.wdata = wd;
    e.g = eg; e.o = eo; e.b = eb; e.y = ey;
    sb.push_back(e);
  endtask

  // Reset lands just after a rising edge, so only an async clear is seen.
  task automatic cyc_rst_mid(
    input logic [3:0] r, input logic [3:0] l, input logic [127:0] wd
  );
    exp_t e;
    @(negedge clk);
    #1;
    bus.req   = r;
    bus.lock  = l;
    bus.wdata = wd;
    e.g = '0; e.o = '0; e.b = 1'b0; e.y = '0;
    sb.push_back(e);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  logic [127:0] rot;
  logic [127:0] z;

  initial begin
    int guard;
    reset     = 1'b0;
    bus.req   = '0;
    bus.lock  = '0;
    bus.wdata = '0;
    rot = pk(32'd4, 32'd3, 32'd2, 32'd1);
    z   = '0;
    repeat (2) @(negedge clk);

    cyc(0, 4'b1111, 4'b0000, rot, 4'b0000, 2'd0, 0, 32'h0);
    cyc(0, 4'b1111, 4'b0000, rot, 4'b0000, 2'd0, 0, 32'h0);

    cyc(1, 4'b1111, 4'b0000, rot, 4'b0001, 2'd0, 1, 32'h0);
    cyc(1, 4'b1111, 4'b0000, rot, 4'b0010, 2'd1, 1, 32'h1);
    cyc(1, 4'b1111, 4'b0000, rot, 4'b0100, 2'd2, 1, 32'h2);
    cyc(1, 4'b1111, 4'b0000, rot, 4'b1000, 2'd3, 1, 32'h3);
    cyc(1, 4'b1111, 4'b0000, rot, 4'b0001, 2'd0, 1, 32'h4);
    cyc(1, 4'b1111, 4'b0000, rot, 4'b0010, 2'd1, 1, 32'h1);
    cyc(1, 4'b0000, 4'b0000, rot, 4'b0000, 2'd0, 0, 32'h1);

    cyc(1, 4'b0100, 4'b0000, pk(0, 32'hDEADBEEF, 0, 0),
        4'b0100, 2'd2, 1, 32'h1);
    cyc(1, 4'b0100, 4'b0000, pk(0, 32'hDEADBEEF, 0, 0),
        4'b0100, 2'd2, 1, 32'hDEADBEEF);
    cyc(1, 4'b0000, 4'b0000, z, 4'b0000, 2'd0, 0, 32'hDEADBEEF);

    cyc(1, 4'b0011, 4'b0001, pk(0, 0, 32'h77, 32'h100),
        4'b0001, 2'd0, 1, 32'hDEADBEEF);
    cyc(1, 4'b0011, 4'b0001, pk(0, 0, 32'h77, 32'h101),
        4'b0001, 2'd0, 1, 32'h101);
    cyc(1, 4'b0011, 4'b0001, pk(0, 0, 32'h77, 32'h102),
        4'b0001, 2'd0, 1, 32'h102);
    cyc(1, 4'b0011, 4'b0001, pk(0, 0, 32'h77, 32'h103),
        4'b0001, 2'd0, 1, 32'h103);
    cyc(1, 4'b0011, 4'b0001, pk(0, 0, 32'h77, 32'h104),
        4'b0010, 2'd1, 1, 32'h104);

    cyc(1, 4'b1000, 4'b0000, pk(32'h55, 0, 32'h66, 0),
        4'b1000, 2'd3, 1, 32'h104);
    cyc(1, 4'b0000, 4'b0000, z, 4'b0000, 2'd0, 0, 32'h104);

    cyc(1, 4'b0001, 4'b0001, pk(0, 0, 0, 32'h200),
        4'b0001, 2'd0, 1, 32'h104);
    cyc(1, 4'b0001, 4'b0001, pk(0, 0, 0, 32'h201),
        4'b0001, 2'd0, 1, 32'h201);
    cyc(1, 4'b0001, 4'b0001, pk(0, 0, 0, 32'h202),
        4'b0001, 2'd0, 1, 32'h202);
    cyc(1, 4'b0001, 4'b0001, pk(0, 0, 0, 32'h203),
        4'b0001, 2'd0, 1, 32'h203);
    cyc(1, 4'b0001, 4'b0001, pk(0, 0, 0, 32'h204),
        4'b0001, 2'd0, 1, 32'h204);
    cyc(1, 4'b0001, 4'b0001, pk(0, 0, 0, 32'h205),
        4'b0001, 2'd0, 1, 32'h205);
    cyc(1, 4'b0001, 4'b0001, pk(0, 0, 0, 32'h206),
        4'b0001, 2'd0, 1, 32'h206);

    cyc_rst_mid(4'b0001, 4'b0001, pk(0, 0, 0, 32'h207));
    cyc(0, 4'b0001, 4'b0001, pk(0, 0, 0, 32'h208),
        4'b0000, 2'd0, 0, 32'h0);

    cyc(1, 4'b0101, 4'b0000, pk(0, 32'h9, 0, 32'h8),
        4'b0001, 2'd0, 1, 32'h0);
    cyc(1, 4'b0000, 4'b0000, z, 4'b0000, 2'd0, 0, 32'h0);
    cyc(1, 4'b1000, 4'b0000, pk(32'h300, 0, 0, 0),
        4'b1000, 2'd3, 1, 32'h0);
    cyc(1, 4'b1000, 4'b0000, pk(32'h300, 0, 0, 0),
        4'b1000, 2'd3, 1, 32'h300);
    cyc(1, 4'b0000, 4'b0000, z, 4'b0000, 2'd0, 0, 32'h300);

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
